// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO registers.
// Multi-cycle mult/div run with a registered busy flag; mthi/mtlo complete in one cycle.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        flush,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             op_signed;
  logic             accept;

  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] div_lo;
  logic [31:0] div_hi;

  assign accept = start & ~flush & ~busy;

  // Sign- or zero-extending to 64 bits makes the low 64 bits of the product correct for both.
  assign ext_a   = {(op_signed ? {32{op_a[31]}} : 32'h0), op_a};
  assign ext_b   = {(op_signed ? {32{op_b[31]}} : 32'h0), op_b};
  assign product = ext_a * ext_b;

  // Signed divide via magnitudes; 0x80000000 / -1 wraps naturally back to 0x80000000.
  assign mag_a  = (op_signed && op_a[31]) ? -op_a : op_a;
  assign mag_b  = (op_signed && op_b[31]) ? -op_b : op_b;
  assign quot   = (mag_b != 32'h0) ? (mag_a / mag_b) : 32'h0;
  assign rem    = (mag_b != 32'h0) ? (mag_a % mag_b) : 32'h0;
  assign div_lo = (op_signed && (op_a[31] ^ op_b[31])) ? -quot : quot;
  assign div_hi = (op_signed && op_a[31]) ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      counter   <= '0;
      hi        <= 32'h0;
      lo        <= 32'h0;
      op_a      <= 32'h0;
      op_b      <= 32'h0;
      op_signed <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (md_op)
              3'd0, 3'd1: begin
                state     <= MULT;
                busy      <= 1'b1;
                counter   <= CNT_W'(1);
                op_a      <= rs_data;
                op_b      <= rt_data;
                op_signed <= ~md_op[0];
              end
              3'd2, 3'd3: begin
                state     <= DIV;
                busy      <= 1'b1;
                counter   <= CNT_W'(1);
                op_a      <= rs_data;
                op_b      <= rt_data;
                op_signed <= ~md_op[0];
              end
              3'd4:    hi <= rs_data;
              3'd5:    lo <= rs_data;
              default: ;
            endcase
          end
        end
        MULT: begin
          if (counter == CNT_W'(MULT_CYCLES)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            hi      <= product[63:32];
            lo      <= product[31:0];
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        DIV: begin
          if (counter == CNT_W'(DIV_CYCLES)) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            // A zero divisor still takes the full latency but leaves HI/LO alone.
            if (op_b != 32'h0) begin
              hi <= div_hi;
              lo <= div_lo;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences, and random operations against a plain-arithmetic model.
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

  logic [31:0] model_hi;
  logic [31:0] model_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        fl;
    int          exp_busy;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[$];

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .flush   (flush),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference behaviour of one issued instruction, straight from the ISA arithmetic.
  function automatic int model_latency(input logic [2:0] op, input logic fl);
    if (fl) return 0;
    if (op == 3'd0 || op == 3'd1) return MULT_CYCLES;
    if (op == 3'd2 || op == 3'd3) return DIV_CYCLES;
    return 0;
  endfunction

  task automatic model_step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    if (!fl) begin
      case (op)
        3'd0: begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          p  = 64'(sa * sb);
          model_hi = p[63:32];
          model_lo = p[31:0];
        end
        3'd1: begin
          p = {32'h0, a} * {32'h0, b};
          model_hi = p[63:32];
          model_lo = p[31:0];
        end
        3'd2: if (b != 0) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          sq = sa / sb;
          sr = sa % sb;
          model_lo = sq[31:0];
          model_hi = sr[31:0];
        end
        3'd3: if (b != 0) begin
          model_lo = a / b;
          model_hi = a % b;
        end
        3'd4: model_hi = a;
        3'd5: model_lo = a;
        default: ;
      endcase
    end
  endtask

  // Issues one instruction at the current negedge and counts the busy cycles that follow.
  task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic fl, output int cycles);
    start   = 1'b1;
    md_op   = op;
    rs_data = a;
    rt_data = b;
    flush   = fl;
    @(posedge clk);
    #1;
    start   = 1'b0;
    flush   = 1'($urandom_range(0, 1));
    md_op   = 3'($urandom);
    rs_data = $urandom;
    rt_data = $urandom;
    cycles  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
    end
    flush = 1'b0;
  endtask

  initial begin
    int          cycles;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        rfl;
    int          exp_cycles;

    checks = 0;
    errors = 0;
    model_hi = 32'h0;
    model_lo = 32'h0;
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    flush = 1'b0;
    rs_data = 32'h0;
    rt_data = 32'h0;

    vecs.push_back('{3'd0, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'h00000002, 1'b0, 5,  32'h00000001, 32'hFFFFFFFE});
    vecs.push_back('{3'd2, 32'hFFFFFFF9, 32'h00000002, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD});
    vecs.push_back('{3'd3, 32'd100,      32'd7,        1'b0, 10, 32'd2,        32'd14});
    vecs.push_back('{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h00000000, 32'h80000000});
    vecs.push_back('{3'd2, 32'd7,        32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD});
    vecs.push_back('{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 5,  32'h3FFFFFFF, 32'h00000001});
    vecs.push_back('{3'd4, 32'h00000011, 32'h0,        1'b0, 0,  32'h00000011, 32'h00000001});
    vecs.push_back('{3'd5, 32'h00000022, 32'h0,        1'b0, 0,  32'h00000011, 32'h00000022});
    vecs.push_back('{3'd3, 32'd5,        32'h0,        1'b0, 10, 32'h00000011, 32'h00000022});
    vecs.push_back('{3'd2, 32'hFFFFFFF0, 32'h0,        1'b0, 10, 32'h00000011, 32'h00000022});
    vecs.push_back('{3'd0, 32'd3,        32'd4,        1'b1, 0,  32'h00000011, 32'h00000022});
    vecs.push_back('{3'd4, 32'hCAFEF00D, 32'h0,        1'b1, 0,  32'h00000011, 32'h00000022});
    vecs.push_back('{3'd4, 32'hDEADBEEF, 32'h0,        1'b0, 0,  32'hDEADBEEF, 32'h00000022});
    vecs.push_back('{3'd5, 32'h12345678, 32'h0,        1'b0, 0,  32'hDEADBEEF, 32'h12345678});
    vecs.push_back('{3'd6, 32'h55555555, 32'h1,        1'b0, 0,  32'hDEADBEEF, 32'h12345678});
    vecs.push_back('{3'd7, 32'hAAAAAAAA, 32'h1,        1'b0, 0,  32'hDEADBEEF, 32'h12345678});

    #12;
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_hi", hi, 32'h0);
    check_output("reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed table; consecutive entries are issued back-to-back after busy falls.
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl, cycles);
      model_step(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fl);
      check_output($sformatf("vec%0d_busy_cycles", i), 32'(cycles), 32'(vecs[i].exp_busy));
      check_output($sformatf("vec%0d_hi", i), hi, vecs[i].exp_hi);
      check_output($sformatf("vec%0d_lo", i), lo, vecs[i].exp_lo);
    end

    // Starts presented while busy must be ignored; the original mult still lands on time.
    start = 1'b1; md_op = 3'd0; rs_data = 32'h00001234; rt_data = 32'h00000010;
    @(posedge clk);
    #1;
    start = 1'b0; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cycles++;
      if (cycles == 2) begin start = 1'b1; md_op = 3'd4; rs_data = 32'hAAAAAAAA; end
      if (cycles == 3) begin md_op = 3'd3; rt_data = 32'd7; end
      if (cycles == 4) start = 1'b0;
    end
    model_step(3'd0, 32'h00001234, 32'h00000010, 1'b0);
    check_output("busy_start_cycles", 32'(cycles), 32'(MULT_CYCLES));
    check_output("busy_start_hi", hi, 32'h00000000);
    check_output("busy_start_lo", lo, 32'h00012340);

    // Reset in the third busy cycle of a mult wipes HI/LO and the result never lands.
    start = 1'b1; md_op = 3'd1; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("midop_reset_busy", 32'(busy), 32'h0);
    check_output("midop_reset_hi", hi, 32'h0);
    check_output("midop_reset_lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check_output("post_reset_busy", 32'(busy), 32'h0);
    check_output("post_reset_hi", hi, 32'h0);
    check_output("post_reset_lo", lo, 32'h0);
    model_hi = 32'h0;
    model_lo = 32'h0;

    // Random instructions against the reference model.
    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20)) ^ {32{rb[31]}};
      rfl = ($urandom_range(0, 7) == 0);
      exp_cycles = model_latency(rop, rfl);
      apply_stimulus(rop, ra, rb, rfl, cycles);
      model_step(rop, ra, rb, rfl);
      check_output($sformatf("rnd%0d_op%0d_busy_cycles", n, rop), 32'(cycles), 32'(exp_cycles));
      check_output($sformatf("rnd%0d_op%0d_hi", n, rop), hi, model_hi);
      check_output($sformatf("rnd%0d_op%0d_lo", n, rop), lo, model_lo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
